// File: rtl/mc_control.sv
// Multicycle RV32 control FSM: FETCH/DECODE/EXEC/MEM/WB/TRAP, outputs decoded from state and instr.
// Optional MC_CONTROL_PERF_EN adds cycle_cnt/instret_cnt performance counters.
module mc_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic [2:0]  imm_select,
  output logic [1:0]  alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        halted
`ifdef MC_CONTROL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  state_t state, state_nx;

  logic [6:0] opc;
  logic       is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr;
  logic       is_lui, is_auipc, is_fence, supported, active;
  logic       unused_instr;

  assign opc          = instr[6:0];
  assign unused_instr = ^instr[31:7];
  assign is_r         = (opc == OP_R);
  assign is_i         = (opc == OP_I);
  assign is_load      = (opc == OP_LOAD);
  assign is_store     = (opc == OP_STORE);
  assign is_branch    = (opc == OP_BRANCH);
  assign is_jal       = (opc == OP_JAL);
  assign is_jalr      = (opc == OP_JALR);
  assign is_lui       = (opc == OP_LUI);
  assign is_auipc     = (opc == OP_AUIPC);
  assign is_fence     = (opc == OP_FENCE);
  assign supported    = is_r | is_i | is_load | is_store | is_branch | is_jal |
                        is_jalr | is_lui | is_auipc | is_fence;
  assign active       = (state == DECODE) || (state == EXEC) || (state == MEM) || (state == WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 1'b0;
    imm_select = 3'b000;
    alu_src_a  = 2'd0;
    alu_src_b  = 1'b0;
    alu_op     = 2'b00;
    reg_we     = 1'b0;
    wb_sel     = 2'd0;
    halted     = 1'b0;

    case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we    = 1'b1;
          state_nx = DECODE;
        end
      end
      DECODE: state_nx = supported ? EXEC : TRAP;
      EXEC: begin
        if (is_branch) begin
          pc_we    = 1'b1;
          pc_sel   = branch_taken;
          state_nx = FETCH;
        end else if (is_fence) begin
          pc_we    = 1'b1;
          state_nx = FETCH;
        end else if (is_load || is_store) begin
          state_nx = MEM;
        end else begin
          state_nx = WB;
        end
      end
      MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_we    = 1'b1;
            state_nx = FETCH;
          end else begin
            state_nx = WB;
          end
        end
      end
      WB: begin
        reg_we   = 1'b1;
        pc_we    = 1'b1;
        pc_sel   = is_jal | is_jalr;
        wb_sel   = (is_jal || is_jalr) ? 2'd2 : (is_load ? 2'd1 : 2'd0);
        state_nx = FETCH;
      end
      TRAP: halted = 1'b1;
      default: state_nx = FETCH;
    endcase

    // Datapath selects are held steady for the whole instruction once decoded.
    if (active) begin
      if (is_i || is_load || is_jalr)  imm_select = 3'b000;
      else if (is_store)               imm_select = 3'b001;
      else if (is_branch)              imm_select = 3'b010;
      else if (is_jal)                 imm_select = 3'b011;
      else if (is_lui || is_auipc)     imm_select = 3'b100;

      // Branch target (PC+imm) is formed in DECODE; EXEC reuses the ALU to compare rs1/rs2.
      if (is_lui)                                   alu_src_a = 2'd2;
      else if (is_auipc || is_jal)                  alu_src_a = 2'd1;
      else if (is_branch && state == DECODE)        alu_src_a = 2'd1;

      alu_src_b = !(is_r || is_branch);

      if (is_branch && state == EXEC) alu_op = 2'b01;
      else if (is_r || is_i)          alu_op = 2'b10;
    end

    // Reset forces every output low without waiting for a clock edge.
    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      addr_sel   = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_sel     = 1'b0;
      imm_select = 3'b000;
      alu_src_a  = 2'd0;
      alu_src_b  = 1'b0;
      alu_op     = 2'b00;
      reg_we     = 1'b0;
      wb_sel     = 2'd0;
      halted     = 1'b0;
    end
  end

`ifdef MC_CONTROL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else if (state != TRAP) begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (pc_we) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: per-opcode vector table plus hand-written multicycle sequences.
module tb_mc_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        branch_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel;
  logic [2:0]  imm_select;
  logic [1:0]  alu_src_a, alu_op, wb_sel;
  logic        alu_src_b, reg_we, halted;
`ifdef MC_CONTROL_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mc_control dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .imm_select(imm_select),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we),
    .wb_sel(wb_sel), .halted(halted)
`ifdef MC_CONTROL_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  imm;
    logic [1:0]  src_a_dec;
    logic        src_b;
    logic [1:0]  op_exec;
    logic        pcwe_exec;
    logic        trap;
    logic        to_wb;
    logic [1:0]  wbs;
    logic        pcs_wb;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hold reset across two edges, release mid-cycle with the DUT in FETCH.
  task automatic do_reset(input logic [31:0] ins, input logic mr);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    branch_taken = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    instr = ins;
    mem_ready = mr;
    #1;
  endtask

  task automatic cycle_in(input logic mr, input logic bt);
    @(posedge clk);
    #2;
    mem_ready = mr;
    branch_taken = bt;
    #1;
  endtask

  function automatic logic [17:0] all_outs();
    return {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, imm_select, alu_src_a,
            alu_src_b, alu_op, reg_we, wb_sel, halted};
  endfunction

  initial begin
    //                instr          imm   srcA   B     op     pcwe  trap  wb    wbs   pcs
    tbl[0]  = '{32'h002081B3, 3'd0, 2'd0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0}; // ADD
    tbl[1]  = '{32'h00500093, 3'd0, 2'd0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0}; // ADDI
    tbl[2]  = '{32'h0000A103, 3'd0, 2'd0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0}; // LW
    tbl[3]  = '{32'h0020A023, 3'd1, 2'd0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0}; // SW
    tbl[4]  = '{32'h00208463, 3'd2, 2'd1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0}; // BEQ
    tbl[5]  = '{32'h008000EF, 3'd3, 2'd1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1}; // JAL
    tbl[6]  = '{32'h000080E7, 3'd0, 2'd0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1}; // JALR
    tbl[7]  = '{32'h123450B7, 3'd4, 2'd2, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0}; // LUI
    tbl[8]  = '{32'h00001097, 3'd4, 2'd1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0}; // AUIPC
    tbl[9]  = '{32'h0000000F, 3'd0, 2'd0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0}; // FENCE
    tbl[10] = '{32'h00000073, 3'd0, 2'd0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0}; // ECALL
    tbl[11] = '{32'h0000007F, 3'd0, 2'd0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0}; // bad op

    // Reset state: everything low while rst_n is asserted.
    #3;
    chk("reset_outs", 32'(all_outs()), 32'd0);

    // ADDI with immediate memory response: FETCH, DECODE, EXEC, WB.
    do_reset(32'h00500093, 1'b1);
    chk("addi_c1_mem_req", mem_req, 1'b1);
    chk("addi_c1_addr_sel", addr_sel, 1'b0);
    chk("addi_c1_ir_we", ir_we, 1'b1);
    cycle_in(1'b0, 1'b0);
    chk("addi_c2_imm", imm_select, 3'd0);
    chk("addi_c2_reg_we", reg_we, 1'b0);
    cycle_in(1'b0, 1'b0);
    chk("addi_c3_reg_we", reg_we, 1'b0);
    chk("addi_c3_pc_we", pc_we, 1'b0);
    cycle_in(1'b0, 1'b0);
    chk("addi_c4_reg_we", reg_we, 1'b1);
    chk("addi_c4_pc_we", pc_we, 1'b1);
    chk("addi_c4_pc_sel", pc_sel, 1'b0);
    cycle_in(1'b0, 1'b0);
    chk("addi_c5_fetch", {mem_req, reg_we, pc_we}, 3'b100);
`ifdef MC_CONTROL_PERF_EN
    chk("perf_cycle_cnt", cycle_cnt, 32'd4);
    chk("perf_instret_cnt", instret_cnt, 32'd1);
`endif
    // FETCH holds the request while memory stalls.
    cycle_in(1'b0, 1'b0);
    chk("fetch_hold_req", {mem_req, ir_we}, 2'b10);

    // BEQ taken.
    do_reset(32'h00208463, 1'b1);
    cycle_in(1'b0, 1'b1);
    chk("beq_dec_imm", imm_select, 3'd2);
    cycle_in(1'b0, 1'b1);
    chk("beq_exec_alu_op", alu_op, 2'b01);
    chk("beq_exec_pc", {pc_we, pc_sel, reg_we}, 3'b110);
    cycle_in(1'b0, 1'b0);
    chk("beq_back_fetch", {mem_req, pc_we, reg_we}, 3'b100);

    // LW with mem_ready arriving on the fourth MEM cycle.
    do_reset(32'h0000A103, 1'b1);
    cycle_in(1'b0, 1'b0);
    cycle_in(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle_in((i == 3), 1'b0);
      chk("lw_mem_req_addr", {mem_req, addr_sel, mem_we}, 3'b110);
    end
    cycle_in(1'b0, 1'b0);
    chk("lw_wb", {mem_req, reg_we, pc_we, wb_sel}, 5'b01101);

    // SW completes from MEM straight back to FETCH.
    do_reset(32'h0020A023, 1'b1);
    cycle_in(1'b0, 1'b0);
    cycle_in(1'b0, 1'b0);
    cycle_in(1'b1, 1'b0);
    chk("sw_mem", {mem_req, addr_sel, mem_we, pc_we, pc_sel, reg_we}, 6'b111100);
    cycle_in(1'b0, 1'b0);
    chk("sw_back_fetch", {mem_req, addr_sel, reg_we}, 3'b100);

    // Unsupported opcode: halt, no strobes regardless of inputs.
    do_reset(32'h00000073, 1'b1);
    cycle_in(1'b1, 1'b0);
    chk("trap_dec_halted", halted, 1'b0);
    cycle_in(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
`ifdef MC_CONTROL_PERF_EN
      logic [31:0] cc;
      cc = cycle_cnt;
`endif
      cycle_in(logic'(i % 2), 1'b1);
      chk("trap_halt_nostrobe", {halted, mem_req, mem_we, ir_we, pc_we, reg_we}, 6'b100000);
`ifdef MC_CONTROL_PERF_EN
      chk("trap_cycle_freeze", cycle_cnt, cc);
`endif
    end

    // Reset asserted mid-MEM drops mem_req without a clock edge.
    do_reset(32'h0000A103, 1'b1);
    cycle_in(1'b0, 1'b0);
    cycle_in(1'b0, 1'b0);
    cycle_in(1'b0, 1'b0);
    chk("mid_mem_req_pre", mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_mem_async_drop", 32'(all_outs()), 32'd0);
    do_reset(32'h0000A103, 1'b0);
    chk("post_reset_fetch", {mem_req, addr_sel, ir_we}, 3'b100);

    // Per-opcode table.
    for (int v = 0; v < 12; v++) begin
      do_reset(tbl[v].instr, 1'b1);
      chk("tbl_fetch_ir_we", ir_we, 1'b1);
      cycle_in(1'b1, 1'b0);
      chk("tbl_dec_imm", imm_select, tbl[v].imm);
      chk("tbl_dec_src_a", alu_src_a, tbl[v].src_a_dec);
      chk("tbl_dec_ir_we", {ir_we, mem_req, halted}, 3'b000);
      cycle_in(1'b0, 1'b0);
      if (tbl[v].trap) begin
        chk("tbl_trap_halted", halted, 1'b1);
      end else begin
        chk("tbl_exec_imm_held", imm_select, tbl[v].imm);
        chk("tbl_exec_src_b", alu_src_b, tbl[v].src_b);
        chk("tbl_exec_alu_op", alu_op, tbl[v].op_exec);
        chk("tbl_exec_pc", {pc_we, pc_sel}, {tbl[v].pcwe_exec, 1'b0});
        if (tbl[v].to_wb) begin
          cycle_in(1'b0, 1'b0);
          chk("tbl_wb_sel", wb_sel, tbl[v].wbs);
          chk("tbl_wb_pc_sel", pc_sel, tbl[v].pcs_wb);
          chk("tbl_wb_strobes", {reg_we, pc_we}, 2'b11);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
